// File: rtl/soc_sysid_checker.sv
// Avalon-MM read master that fetches the sysid ID and timestamp words after reset or on request,
// compares them with build-time constants and reports pass/mismatch/timeout to boot logic.
module soc_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = 32'h637A_0378,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam logic [15:0] WaitLast = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  RetryMax = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    StIdle,
    StRdId,
    StRdTs,
    StRetry,
    StCheck,
    StDone
  } state_e;

  state_e      state_q;
  logic        auto_q;
  logic [15:0] wait_cnt_q;
  logic [3:0]  retry_cnt_q;
  logic        addr_q;
  logic        read_q;
  logic        busy_q;
  logic        done_q;
  logic        pass_q;
  logic        id_mis_q;
  logic        ts_mis_q;
  logic        timeout_q;
  logic [31:0] id_q;
  logic [31:0] ts_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      auto_q      <= AUTO_START;
      wait_cnt_q  <= '0;
      retry_cnt_q <= '0;
      addr_q      <= 1'b0;
      read_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      id_mis_q    <= 1'b0;
      ts_mis_q    <= 1'b0;
      timeout_q   <= 1'b0;
      id_q        <= '0;
      ts_q        <= '0;
    end else begin
      // Auto-start only applies to the first cycle after reset release.
      auto_q <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start || auto_q) begin
            state_q     <= StRdId;
            busy_q      <= 1'b1;
            read_q      <= 1'b1;
            addr_q      <= 1'b0;
            wait_cnt_q  <= '0;
            retry_cnt_q <= '0;
            pass_q      <= 1'b0;
            id_mis_q    <= 1'b0;
            ts_mis_q    <= 1'b0;
            timeout_q   <= 1'b0;
          end
        end
        StRdId, StRdTs: begin
          if (!avm_waitrequest) begin
            wait_cnt_q <= '0;
            if (state_q == StRdId) begin
              id_q    <= avm_readdata;
              addr_q  <= 1'b1;
              state_q <= StRdTs;
            end else begin
              ts_q    <= avm_readdata;
              read_q  <= 1'b0;
              state_q <= StCheck;
            end
          end else if (wait_cnt_q == WaitLast) begin
            read_q  <= 1'b0;
            state_q <= StRetry;
          end else begin
            wait_cnt_q <= wait_cnt_q + 16'd1;
          end
        end
        StRetry: begin
          if (retry_cnt_q < RetryMax) begin
            // Reissue the same word; addr_q still holds the abandoned address.
            retry_cnt_q <= retry_cnt_q + 4'd1;
            wait_cnt_q  <= '0;
            read_q      <= 1'b1;
            state_q     <= addr_q ? StRdTs : StRdId;
          end else begin
            timeout_q <= 1'b1;
            pass_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= StDone;
          end
        end
        StCheck: begin
          id_mis_q <= (id_q != EXPECTED_ID);
          ts_mis_q <= (ts_q != EXPECTED_TS);
          pass_q   <= (id_q == EXPECTED_ID) && (ts_q == EXPECTED_TS);
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= StDone;
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          read_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign avm_address = addr_q;
  assign avm_read    = read_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign id_mismatch = id_mis_q;
  assign ts_mismatch = ts_mis_q;
  assign timeout     = timeout_q;
  assign id_value    = id_q;
  assign ts_value    = ts_q;

endmodule

// File: tb/tb_soc_sysid_checker.sv
// Randomized bench: a stalling sysid slave drives two checker instances and a run-level model
// predicts done latency, read-cycle counts and the reported result.
module tb_soc_sysid_checker;

  localparam logic [31:0] ExpId = 32'h0000_0000;
  localparam logic [31:0] ExpTs = 32'h637A_0378;
  localparam int TimeoutA = 255;
  localparam int RetriesA = 3;
  localparam int TimeoutB = 4;
  localparam int RetriesB = 2;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n;
  logic        start_v;
  logic        wr_v;
  logic [31:0] rdata_v;
  int          sel;

  logic        a_start, a_wr, a_addr, a_read, a_busy, a_done, a_pass, a_idm, a_tsm, a_to;
  logic [31:0] a_idv, a_tsv;
  logic        b_start, b_wr, b_addr, b_read, b_busy, b_done, b_pass, b_idm, b_tsm, b_to;
  logic [31:0] b_idv, b_tsv;

  assign a_start = (sel == 0) && start_v;
  assign b_start = (sel == 1) && start_v;
  assign a_wr    = (sel == 0) ? wr_v : 1'b0;
  assign b_wr    = (sel == 1) ? wr_v : 1'b0;

  soc_sysid_checker #(
    .EXPECTED_ID   (ExpId),
    .EXPECTED_TS   (ExpTs),
    .TIMEOUT_CYCLES(TimeoutA),
    .MAX_RETRIES   (RetriesA),
    .AUTO_START    (1'b1)
  ) u_dut_a (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (a_start),
    .avm_address    (a_addr),
    .avm_read       (a_read),
    .avm_waitrequest(a_wr),
    .avm_readdata   (rdata_v),
    .busy           (a_busy),
    .done           (a_done),
    .pass           (a_pass),
    .id_mismatch    (a_idm),
    .ts_mismatch    (a_tsm),
    .timeout        (a_to),
    .id_value       (a_idv),
    .ts_value       (a_tsv)
  );

  soc_sysid_checker #(
    .EXPECTED_ID   (ExpId),
    .EXPECTED_TS   (ExpTs),
    .TIMEOUT_CYCLES(TimeoutB),
    .MAX_RETRIES   (RetriesB),
    .AUTO_START    (1'b0)
  ) u_dut_b (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (b_start),
    .avm_address    (b_addr),
    .avm_read       (b_read),
    .avm_waitrequest(b_wr),
    .avm_readdata   (rdata_v),
    .busy           (b_busy),
    .done           (b_done),
    .pass           (b_pass),
    .id_mismatch    (b_idm),
    .ts_mismatch    (b_tsm),
    .timeout        (b_to),
    .id_value       (b_idv),
    .ts_value       (b_tsv)
  );

  logic        rd_s, addr_s, busy_s, done_s, pass_s, idm_s, tsm_s, to_s;
  logic [31:0] idv_s, tsv_s;
  assign rd_s   = sel ? b_read : a_read;
  assign addr_s = sel ? b_addr : a_addr;
  assign busy_s = sel ? b_busy : a_busy;
  assign done_s = sel ? b_done : a_done;
  assign pass_s = sel ? b_pass : a_pass;
  assign idm_s  = sel ? b_idm  : a_idm;
  assign tsm_s  = sel ? b_tsm  : a_tsm;
  assign to_s   = sel ? b_to   : a_to;
  assign idv_s  = sel ? b_idv  : a_idv;
  assign tsv_s  = sel ? b_tsv  : a_tsv;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Slave stall length for each successive read attempt of a run; missing entries mean no stall.
  int          stalls[$];
  logic [31:0] prev_id[2];
  logic [31:0] prev_ts[2];

  // Called just after a falling edge; returns in the first idle cycle after the done pulse.
  task automatic run(input logic [31:0] idw, input logic [31:0] tsw, input bit use_start,
                     input bit poke_busy, input bit poke_done);
    int t_lim, m_lim, sum, retries, phase, idx, s, exp_done_k;
    int exp_rd[2];
    int got_rd[2];
    bit to;
    int k, got_done_k, busy_bad, att, cnt, cur, idle_bad;
    bit in_att, rd_now;
    logic e_pass, e_idm, e_tsm;
    logic [31:0] e_idv, e_tsv;

    t_lim = sel ? TimeoutB : TimeoutA;
    m_lim = sel ? RetriesB : RetriesA;
    sum = 0; retries = 0; phase = 0; idx = 0; to = 1'b0;
    exp_rd[0] = 0; exp_rd[1] = 0;
    while (1) begin
      s = (idx < stalls.size()) ? stalls[idx] : 0;
      idx++;
      if (s >= t_lim) begin
        sum += t_lim + 1;
        exp_rd[phase] += t_lim;
        if (retries < m_lim) retries++;
        else begin
          to = 1'b1;
          break;
        end
      end else begin
        sum += s + 1;
        exp_rd[phase] += s + 1;
        phase++;
        if (phase == 2) break;
      end
    end
    exp_done_k = to ? sum + 1 : sum + 2;
    e_pass = !to && (idw == ExpId) && (tsw == ExpTs);
    e_idm  = !to && (idw != ExpId);
    e_tsm  = !to && (tsw != ExpTs);
    e_idv  = (phase >= 1) ? idw : prev_id[sel];
    e_tsv  = (phase >= 2) ? tsw : prev_ts[sel];

    if (use_start) start_v = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start_v = 1'b0;

    k = 1; got_done_k = -1; busy_bad = 0; att = 0; cnt = 0; cur = 0; in_att = 1'b0;
    got_rd[0] = 0; got_rd[1] = 0;
    while (k <= 3000) begin
      if (k == 1) check("flags_cleared", {27'd0, pass_s, idm_s, tsm_s, to_s, done_s}, 32'd0);
      rd_now = rd_s;
      if (rd_s) begin
        if (!in_att) begin
          in_att = 1'b1;
          cnt = 0;
          cur = (att < stalls.size()) ? stalls[att] : 0;
          att++;
        end
        wr_v = (cnt < cur);
        rdata_v = wr_v ? $urandom : (addr_s ? tsw : idw);
        got_rd[int'(addr_s)]++;
      end else begin
        in_att = 1'b0;
        wr_v = 1'($urandom % 2);
        rdata_v = $urandom;
      end
      if (busy_s !== !done_s) busy_bad++;
      if (done_s) begin
        got_done_k = k;
        break;
      end
      start_v = poke_busy && (k == 2);
      @(posedge clock);
      if (rd_now && !wr_v) in_att = 1'b0;
      else if (rd_now) cnt++;
      @(negedge clock);
      k++;
    end

    check("done_latency", 32'(got_done_k), 32'(exp_done_k));
    check("id_read_cycles", 32'(got_rd[0]), 32'(exp_rd[0]));
    check("ts_read_cycles", 32'(got_rd[1]), 32'(exp_rd[1]));
    check("busy_profile", 32'(busy_bad), 32'd0);
    check("result_flags", {28'd0, pass_s, idm_s, tsm_s, to_s}, {28'd0, e_pass, e_idm, e_tsm, to});
    check("id_value", idv_s, e_idv);
    check("ts_value", tsv_s, e_tsv);
    prev_id[sel] = e_idv;
    prev_ts[sel] = e_tsv;

    start_v = poke_done;
    wr_v = 1'b0;
    @(posedge clock);
    @(negedge clock);
    start_v = 1'b0;
    check("after_done", {29'd0, rd_s, busy_s, done_s}, 32'd0);
    if (poke_done) begin
      idle_bad = 0;
      repeat (3) begin
        @(posedge clock);
        @(negedge clock);
        if (rd_s || busy_s || done_s) idle_bad++;
      end
      check("start_in_done_ignored", 32'(idle_bad), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] idw, tsw;
    sel = 0; start_v = 1'b0; wr_v = 1'b0; rdata_v = '0; reset_n = 1'b0;
    prev_id[0] = '0; prev_id[1] = '0; prev_ts[0] = '0; prev_ts[1] = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_a", {24'd0, a_read, a_addr, a_busy, a_done, a_pass, a_idm, a_tsm, a_to}, 32'd0);
    check("reset_b", {24'd0, b_read, b_addr, b_busy, b_done, b_pass, b_idm, b_tsm, b_to}, 32'd0);
    check("reset_vals", a_idv | a_tsv | b_idv | b_tsv, 32'd0);

    // Auto-start run on instance A, then back-to-back started runs.
    reset_n = 1'b1;
    stalls = {};
    run(ExpId, ExpTs, 1'b0, 1'b0, 1'b0);
    run(32'h0000_0001, ExpTs, 1'b1, 1'b0, 1'b0);
    stalls = {0, 5};
    run(ExpId, ExpTs, 1'b1, 1'b1, 1'b1);

    // Instance B with the slave stuck busy exhausts its retries.
    sel = 1;
    stalls = {100, 100, 100, 100};
    run(ExpId, ExpTs, 1'b1, 1'b0, 1'b0);
    stalls = {};
    run(32'h1234_5678, 32'h0BAD_F00D, 1'b1, 1'b0, 1'b0);

    // Reset while A is stalled on the timestamp read.
    sel = 0;
    start_v = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start_v = 1'b0;
    rdata_v = 32'hDEAD_BEEF;
    repeat (3) begin
      wr_v = a_addr;
      @(posedge clock);
      @(negedge clock);
    end
    check("stalled_ts_read", {30'd0, a_read, a_addr}, 32'd3);
    reset_n = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("mid_reset_a", {24'd0, a_read, a_addr, a_busy, a_done, a_pass, a_idm, a_tsm, a_to}, 32'd0);
    check("mid_reset_vals", a_idv | a_tsv, 32'd0);
    prev_id[0] = '0; prev_ts[0] = '0;
    reset_n = 1'b1;
    wr_v = 1'b0;
    stalls = {};
    run(ExpId, ExpTs, 1'b0, 1'b0, 1'b0);

    for (int r = 0; r < 40; r++) begin
      sel = int'($urandom % 2);
      idw = ($urandom % 2) ? ExpId : $urandom;
      tsw = ($urandom % 2) ? ExpTs : $urandom;
      stalls = {};
      for (int i = 0; i < 6; i++) begin
        if ($urandom % 16 == 0) stalls.push_back(sel ? 7 : 300);
        else if ($urandom % 3 == 0) stalls.push_back(int'($urandom_range(1, 6)));
        else stalls.push_back(0);
      end
      run(idw, tsw, 1'b1, 1'($urandom % 2), 1'($urandom % 4 == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
